// File: rtl/minutos_horas.sv
// minutos_horas: minutes/hours counter driven by the seconds-counter carry.
//   Also handles manual time setting and emits a one-cycle day carry at 23:59 -> 00:00.
//   Outputs are registered and update at the posedge where an input rising edge is seen.
//   Optional feature macro: AUTO_REPEAT_EN. When defined, a held button in adjust mode
//   auto-repeats every REPEAT_CYCLES clocks.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   inc_i      seconds carry (level); one minute per rising edge in run mode
//   alt_i      1 = adjust mode (normal counting suspended)
//   sel_i      adjust field select: 0 = minutes, 1 = hours
//   btn_up_i   increment button (already synchronised); one step per rising edge
//   minutos_o  minutes 0..59
//   horas_o    hours 0..MAX_HORAS-1
//   inc_o      day carry, one-cycle pulse
module minutos_horas #(
   parameter int MAX_HORAS     = 24,
   parameter int REPEAT_CYCLES = 25_000_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       inc_i,
   input  logic       alt_i,
   input  logic       sel_i,
   input  logic       btn_up_i,
   output logic [5:0] minutos_o,
   output logic [4:0] horas_o,
   output logic       inc_o
);

   localparam logic [5:0] MIN_MAX = 6'd59;
   localparam logic [4:0] HOR_MAX = 5'(MAX_HORAS - 1);

   logic [5:0] min_q, min_d;
   logic [4:0] hor_q, hor_d;
   logic       day_q, day_d;
   logic       inc_prev_q;
   logic       btn_prev_q;

   logic       inc_edge;
   logic       btn_edge;
   logic       adj_step;

   assign inc_edge = inc_i & ~inc_prev_q;
   assign btn_edge = btn_up_i & ~btn_prev_q;

`ifdef AUTO_REPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_q, rep_d;
   logic          rep_fire;

   // The button edge itself gives the first step, so the edge restarts the count.
   always_comb begin
      rep_d    = '0;
      rep_fire = 1'b0;
      if (alt_i && btn_up_i && !btn_edge) begin
         if (rep_q == REP_LAST) begin
            rep_fire = 1'b1;
            rep_d    = '0;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end

   assign adj_step = btn_edge | rep_fire;
`else
   // Keeps the parameter referenced in builds without auto-repeat.
   logic [31:0] rep_cycles_unused;
   assign rep_cycles_unused = REPEAT_CYCLES;

   assign adj_step = btn_edge;
`endif

   // Next-state: run-mode carry chain, or single-field step with wrap in adjust mode.
   // ">=" compares make any forced out-of-range value wrap to 0 on the next step.
   always_comb begin
      min_d = min_q;
      hor_d = hor_q;
      day_d = 1'b0;
      if (!alt_i) begin
         if (inc_edge) begin
            if (min_q >= MIN_MAX) begin
               min_d = '0;
               if (hor_q >= HOR_MAX) begin
                  hor_d = '0;
                  day_d = 1'b1;
               end else begin
                  hor_d = hor_q + 5'd1;
               end
            end else begin
               min_d = min_q + 6'd1;
            end
         end
      end else if (adj_step) begin
         if (sel_i) begin
            hor_d = (hor_q >= HOR_MAX) ? 5'd0 : hor_q + 5'd1;
         end else begin
            min_d = (min_q >= MIN_MAX) ? 6'd0 : min_q + 6'd1;
         end
      end
   end

   // History registers reset to 1 so an input already high at release is not an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         min_q      <= '0;
         hor_q      <= '0;
         day_q      <= 1'b0;
         inc_prev_q <= 1'b1;
         btn_prev_q <= 1'b1;
      end else begin
         min_q      <= min_d;
         hor_q      <= hor_d;
         day_q      <= day_d;
         inc_prev_q <= inc_i;
         btn_prev_q <= btn_up_i;
      end
   end

   assign minutos_o = min_q;
   assign horas_o   = hor_q;
   assign inc_o     = day_q;

endmodule

// File: tb/tb_minutos_horas.sv
module tb_minutos_horas;

   localparam int MH = 24;
   localparam int RC = 4;

   logic       clk = 1'b0;
   logic       rst_i, inc_i, alt_i, sel_i, btn_up_i;
   logic [5:0] minutos_o;
   logic [4:0] horas_o;
   logic       inc_o;

   minutos_horas #(.MAX_HORAS(MH), .REPEAT_CYCLES(RC)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .inc_i     (inc_i),
      .alt_i     (alt_i),
      .sel_i     (sel_i),
      .btn_up_i  (btn_up_i),
      .minutos_o (minutos_o),
      .horas_o   (horas_o),
      .inc_o     (inc_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0] m;
      logic [4:0] h;
      logic       c;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   inc_seen = 0;

   // Reference model state
   int m_min = 0, m_hor = 0, m_rep = 0;
   bit m_ip = 1'b1, m_bp = 1'b1;

   task automatic m_field_step(input bit s);
      if (s) m_hor = (m_hor >= MH - 1) ? 0 : m_hor + 1;
      else   m_min = (m_min >= 59) ? 0 : m_min + 1;
   endtask

   // One clock: drive inputs, predict, push; after the edge pop and compare.
   task automatic cyc(input bit r, input bit i, input bit a, input bit s, input bit b);
      exp_t e;
      bit   ie, be, c;
      @(negedge clk);
      rst_i = r; inc_i = i; alt_i = a; sel_i = s; btn_up_i = b;
      c = 1'b0;
      if (r) begin
         m_min = 0; m_hor = 0; m_rep = 0; m_ip = 1'b1; m_bp = 1'b1;
      end else begin
         ie = i & ~m_ip;
         be = b & ~m_bp;
         if (!a && ie) begin
            if (m_min == 59) begin
               m_min = 0;
               if (m_hor == MH - 1) begin m_hor = 0; c = 1'b1; end
               else m_hor = m_hor + 1;
            end else m_min = m_min + 1;
         end
         if (a && be) m_field_step(s);
`ifdef AUTO_REPEAT_EN
         if (!a || !b || be) m_rep = 0;
         else if (m_rep == RC - 1) begin m_field_step(s); m_rep = 0; end
         else m_rep = m_rep + 1;
`endif
         m_ip = i;
         m_bp = b;
      end
      e.m = 6'(m_min); e.h = 5'(m_hor); e.c = c;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if ({minutos_o, horas_o, inc_o} !== {e.m, e.h, e.c}) begin
         errors++;
         $display("FAIL cycle t=%0t: got m=%0d h=%0d c=%b, expected m=%0d h=%0d c=%b",
                  $time, minutos_o, horas_o, inc_o, e.m, e.h, e.c);
      end
      if (inc_o === 1'b1) inc_seen++;
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      checks++;
      if ({minutos_o, horas_o, inc_o} !== 12'd0) begin
         errors++;
         $display("FAIL reset: got m=%0d h=%0d c=%b, expected 0 0 0", minutos_o, horas_o, inc_o);
      end
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_run_60();
      do_reset();
      inc_seen = 0;
      for (int p = 0; p < 60; p++) begin
         repeat (3) cyc(0, 1, 0, 0, 0);
         repeat (2) cyc(0, 0, 0, 0, 0);
      end
      checks++;
      if (minutos_o !== 6'd0 || horas_o !== 5'd1) begin
         errors++;
         $display("FAIL run_60: got %0d:%0d, expected 1:0", horas_o, minutos_o);
      end
      checks++;
      if (inc_seen !== 0) begin
         errors++;
         $display("FAIL run_60_carry: inc_o high %0d cycles, expected 0", inc_seen);
      end
   endtask

   task automatic test_day_wrap();
      do_reset();
      for (int p = 0; p < 23; p++) begin cyc(0, 0, 1, 1, 1); cyc(0, 0, 1, 1, 0); end
      for (int p = 0; p < 59; p++) begin cyc(0, 0, 1, 0, 1); cyc(0, 0, 1, 0, 0); end
      checks++;
      if (horas_o !== 5'd23 || minutos_o !== 6'd59) begin
         errors++;
         $display("FAIL set_2359: got %0d:%0d, expected 23:59", horas_o, minutos_o);
      end
      // alt_i falls in the same cycle as the inc_i edge: counts normally
      cyc(0, 1, 0, 0, 0);
      checks++;
      if ({minutos_o, horas_o, inc_o} !== {6'd0, 5'd0, 1'b1}) begin
         errors++;
         $display("FAIL day_wrap: got m=%0d h=%0d c=%b, expected 0 0 1", minutos_o, horas_o, inc_o);
      end
      cyc(0, 1, 0, 0, 0);
      checks++;
      if (inc_o !== 1'b0) begin
         errors++;
         $display("FAIL day_pulse_len: got c=%b, expected 0", inc_o);
      end
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_adjust_hours();
      do_reset();
      inc_seen = 0;
      for (int p = 0; p < 25; p++) begin
         cyc(0, 1, 1, 1, 1);
         cyc(0, 0, 1, 1, 0);
      end
      checks++;
      if (horas_o !== 5'd1 || minutos_o !== 6'd0 || inc_seen !== 0) begin
         errors++;
         $display("FAIL adjust_hours: got %0d:%0d carries=%0d, expected 1:0 carries=0",
                  horas_o, minutos_o, inc_seen);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      cyc(0, 1, 1, 0, 0);   // alt_i rises with the inc_i edge: dropped
      cyc(0, 1, 0, 0, 0);   // still high, no new edge
      checks++;
      if (minutos_o !== 6'd0) begin
         errors++;
         $display("FAIL alt_wins: got m=%0d, expected 0", minutos_o);
      end
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 1);   // sel_i changes with the button edge: new sel used
      checks++;
      if (horas_o !== 5'd1 || minutos_o !== 6'd0) begin
         errors++;
         $display("FAIL sel_new: got %0d:%0d, expected 1:0", horas_o, minutos_o);
      end
      cyc(0, 0, 1, 1, 0);
   endtask

   task automatic test_inc_across_reset();
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      repeat (3) cyc(0, 1, 0, 0, 0);
      checks++;
      if (minutos_o !== 6'd0) begin
         errors++;
         $display("FAIL inc_held_reset: got m=%0d, expected 0", minutos_o);
      end
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      checks++;
      if (minutos_o !== 6'd1) begin
         errors++;
         $display("FAIL inc_fresh_edge: got m=%0d, expected 1", minutos_o);
      end
      cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_repeat();
      int want;
`ifdef AUTO_REPEAT_EN
      want = 4;
`else
      want = 1;
`endif
      do_reset();
      cyc(0, 0, 1, 0, 0);
      repeat (13) cyc(0, 0, 1, 0, 1);
      cyc(0, 0, 1, 0, 0);
      checks++;
      if (minutos_o !== 6'(want)) begin
         errors++;
         $display("FAIL held_button: got m=%0d, expected %0d", minutos_o, want);
      end
   endtask

   task automatic test_reset_mid_adjust();
      do_reset();
      cyc(0, 0, 1, 0, 0);
      repeat (2) cyc(0, 0, 1, 0, 1);
      cyc(1, 0, 1, 0, 1);
      checks++;
      if ({minutos_o, horas_o, inc_o} !== 12'd0) begin
         errors++;
         $display("FAIL reset_mid_adjust: got m=%0d h=%0d c=%b, expected 0 0 0",
                  minutos_o, horas_o, inc_o);
      end
      repeat (3) cyc(0, 0, 1, 0, 1);
      checks++;
      if (minutos_o !== 6'd0) begin
         errors++;
         $display("FAIL btn_held_reset: got m=%0d, expected 0", minutos_o);
      end
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 1);
      checks++;
      if (minutos_o !== 6'd1) begin
         errors++;
         $display("FAIL btn_fresh_edge: got m=%0d, expected 1", minutos_o);
      end
      cyc(0, 0, 1, 0, 0);
   endtask

   initial begin
      rst_i = 1'b1; inc_i = 1'b0; alt_i = 1'b0; sel_i = 1'b0; btn_up_i = 1'b0;
      test_reset();
      test_run_60();
      test_day_wrap();
      test_adjust_hours();
      test_simultaneous();
      test_inc_across_reset();
      test_repeat();
      test_reset_mid_adjust();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
